pref_req_issuer: RTL and testbench

// Requester-side counterpart of the prefetch round-robin arbiter. Buffers prefetch line requests

---
 rtl/pref_pkg.sv | 21 ++
 rtl/pref_src_fifo.sv | 58 +++++
 rtl/pref_req_issuer.sv | 110 +++++++++++
 tb/tb_pref_req_issuer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pref_pkg.sv
// rtl/pref_pkg.sv - shared types and helpers for the prefetch request issuer
package pref_pkg;

  localparam int MAX_SRC = 32;

  typedef logic [31:0] addr_t;

  function automatic int src_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int onehot_to_idx(input logic [MAX_SRC-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_SRC; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/pref_src_fifo.sv
// rtl/pref_src_fifo.sv - per-source request FIFO with registered full/empty
module pref_src_fifo #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // full is taken from the registered count, so a same-cycle pop never opens room
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pref_req_issuer.sv
// rtl/pref_req_issuer.sv - buffers per-source prefetch requests and issues arbiter-granted entries
module pref_req_issuer
  import pref_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]     src_addr,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic [NUM_SRC-1:0]            arb_request,
  input  logic [NUM_SRC-1:0]            arb_grant,
  input  logic                          arb_any_grant,
  output logic                          out_valid,
  output logic [ADDR_W-1:0]             out_addr,
  output logic [src_idx_w(NUM_SRC)-1:0] out_src,
  input  logic                          out_ready,
  output logic                          err_grant
);

  localparam int SRC_W = src_idx_w(NUM_SRC);

  logic [NUM_SRC-1:0] full, empty, pop;
  logic [ADDR_W-1:0]  head [NUM_SRC];
  logic               slot_free, grant_onehot, grant_stray, valid_grant, proto_err;
  logic [MAX_SRC-1:0] grant_ext;
  logic [SRC_W-1:0]   grant_idx;
  logic [ADDR_W-1:0]  head_sel;

  logic               out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]  out_addr_q, out_addr_d;
  logic [SRC_W-1:0]   out_src_q, out_src_d;
  logic               err_q, err_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    pref_src_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (src_valid[i]),
      .push_data (src_addr[i*ADDR_W +: ADDR_W]),
      .pop       (pop[i]),
      .head      (head[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );
  end

  assign src_ready = ~full;
  // a blocked slot withdraws every request so the arbiter pointer stays put
  assign slot_free   = !out_valid_q || out_ready;
  assign arb_request = ~empty & {NUM_SRC{slot_free}};

  assign grant_onehot = (arb_grant != '0) && ((arb_grant & (arb_grant - 1'b1)) == '0);
  assign grant_stray  = (arb_grant & ~arb_request) != '0;
  assign valid_grant  = grant_onehot && !grant_stray && arb_any_grant;
  assign proto_err    = ((arb_grant != '0) && (arb_request == '0))
                      || ((arb_grant != '0) && !grant_onehot)
                      || grant_stray
                      || (arb_any_grant != (|arb_grant));

  assign pop = arb_grant & {NUM_SRC{valid_grant}};

  always_comb begin
    grant_ext                = '0;
    grant_ext[NUM_SRC-1:0]   = arb_grant;
  end

  assign grant_idx = SRC_W'(onehot_to_idx(grant_ext));
  assign head_sel  = head[grant_idx];

  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_src_d   = out_src_q;
    if (valid_grant) begin
      out_valid_d = 1'b1;
      out_addr_d  = head_sel;
      out_src_d   = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    err_d = err_q | proto_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_src_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_src_q   <= out_src_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_src   = out_src_q;
  assign err_grant = err_q;

endmodule

// File: tb/tb_pref_req_issuer.sv
// tb/tb_pref_req_issuer.sv - randomized and directed bench against a queue-based reference model
module tb_pref_req_issuer;
  import pref_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  src_valid, src_ready, arb_request, arb_grant;
  logic [N*AW-1:0] src_addr;
  logic          arb_any_grant, out_valid, out_ready, err_grant;
  logic [AW-1:0] out_addr;
  logic [1:0]    out_src;

  int total = 0;
  int bad   = 0;

  addr_t mq [N][$];
  logic  m_ov;
  addr_t m_oa;
  int    m_os;
  logic  m_err;
  int    rr_ptr;

  logic [N*AW-1:0] sa;

  pref_req_issuer #(.NUM_SRC(N), .ADDR_W(AW), .DEPTH(D)) dut (
    .clk           (clk),
    .reset         (reset),
    .src_valid     (src_valid),
    .src_addr      (src_addr),
    .src_ready     (src_ready),
    .arb_request   (arb_request),
    .arb_grant     (arb_grant),
    .arb_any_grant (arb_any_grant),
    .out_valid     (out_valid),
    .out_addr      (out_addr),
    .out_src       (out_src),
    .out_ready     (out_ready),
    .err_grant     (err_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_ov   = 1'b0;
    m_oa   = '0;
    m_os   = 0;
    m_err  = 1'b0;
    rr_ptr = N - 1;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle(input logic [N-1:0] sv, input logic [N*AW-1:0] a, input logic ordy,
                       input bit inj, input logic [N-1:0] ig, input logic ia);
    logic [N-1:0] req, g, exp_rdy;
    logic         any, legal;
    int           gi, s;
    bit           fullv [N];
    src_valid = sv;
    src_addr  = a;
    out_ready = ordy;
    req = '0;
    exp_rdy = '0;
    for (int i = 0; i < N; i++) begin
      if (mq[i].size() != 0 && (!m_ov || ordy)) req[i] = 1'b1;
      exp_rdy[i] = (mq[i].size() < D);
    end
    g = '0;
    any = 1'b0;
    if (inj) begin
      g = ig;
      any = ia;
    end else begin
      for (int k = 1; k <= N; k++) begin
        s = (rr_ptr + k) % N;
        if (req[s] && g == '0) begin
          g[s] = 1'b1;
          any = 1'b1;
        end
      end
    end
    arb_grant = g;
    arb_any_grant = any;
    #1;
    chk("src_ready",   64'(src_ready),   64'(exp_rdy));
    chk("arb_request", 64'(arb_request), 64'(req));
    chk("out_valid",   64'(out_valid),   64'(m_ov));
    chk("out_addr",    64'(out_addr),    64'(m_oa));
    chk("out_src",     64'(out_src),     64'(m_os));
    chk("err_grant",   64'(err_grant),   64'(m_err));
    legal = ($countones(g) == 1) && any && ((g & ~req) == '0);
    if (!legal && (g != '0 || any)) m_err = 1'b1;
    for (int i = 0; i < N; i++) fullv[i] = (mq[i].size() >= D);
    if (legal) begin
      gi = 0;
      for (int i = 0; i < N; i++) if (g[i]) gi = i;
      m_oa   = mq[gi].pop_front();
      m_os   = gi;
      m_ov   = 1'b1;
      rr_ptr = gi;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (sv[i] && !fullv[i]) mq[i].push_back(a[i*AW +: AW]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    cycle('0, '0, ordy, 1'b0, '0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    src_valid = '0;
    src_addr = '0;
    arb_grant = '0;
    arb_any_grant = 1'b0;
    out_ready = 1'b0;
    model_clear();
    @(negedge clk);
    chk("rst_src_ready",   64'(src_ready),   64'hf);
    chk("rst_arb_request", 64'(arb_request), 64'h0);
    chk("rst_out_valid",   64'(out_valid),   64'h0);
    chk("rst_out_addr",    64'(out_addr),    64'h0);
    chk("rst_err",         64'(err_grant),   64'h0);
    reset = 1'b0;

    // single push on source 2, issued two edges later
    sa = '0;
    sa[2*AW +: AW] = 32'h1000;
    cycle(4'b0100, sa, 1'b1, 1'b0, '0, 1'b0);
    idle(1'b1);
    chk("single_valid", 64'(out_valid), 64'h1);
    chk("single_addr",  64'(out_addr),  64'h1000);
    chk("single_src",   64'(out_src),   64'h2);

    // fill source 0 and queue 1 and 3 behind a blocked output
    sa = '0;
    sa[0 +: AW] = 32'hA0;
    cycle(4'b0001, sa, 1'b0, 1'b0, '0, 1'b0);
    sa = '0;
    sa[0 +: AW] = 32'hA1;
    sa[1*AW +: AW] = 32'hB0;
    sa[3*AW +: AW] = 32'hD0;
    cycle(4'b1011, sa, 1'b0, 1'b0, '0, 1'b0);
    chk("full_src_ready0", 64'(src_ready[0]), 64'h0);
    sa = '0;
    sa[0 +: AW] = 32'hA2;
    cycle(4'b0001, sa, 1'b0, 1'b0, '0, 1'b0);
    chk("bp_request", 64'(arb_request), 64'h0);
    chk("bp_addr",    64'(out_addr),    64'h1000);
    chk("bp_valid",   64'(out_valid),   64'h1);
    idle(1'b1);
    chk("release_valid", 64'(out_valid), 64'h1);
    chk("release_src",   64'(out_src),   64'h3);
    chk("release_addr",  64'(out_addr),  64'hD0);
    idle(1'b1);
    chk("pop_src_ready0", 64'(src_ready[0]), 64'h1);
    chk("pop_addr",       64'(out_addr),     64'hA0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("drop_drained", 64'(arb_request), 64'h0);

    // asynchronous reset with two entries queued
    sa = '0;
    sa[0 +: AW] = 32'h11;
    sa[1*AW +: AW] = 32'h22;
    cycle(4'b0011, sa, 1'b0, 1'b0, '0, 1'b0);
    src_valid = '0;
    arb_grant = '0;
    arb_any_grant = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_request",   64'(arb_request), 64'h0);
    chk("mid_rst_out_valid", 64'(out_valid),   64'h0);
    chk("mid_rst_src_ready", 64'(src_ready),   64'hf);
    model_clear();
    @(negedge clk);
    reset = 1'b0;

    // all four sources queued together issue in round-robin order
    sa = '0;
    for (int i = 0; i < N; i++) sa[i*AW +: AW] = 32'h100 + i;
    cycle(4'b1111, sa, 1'b1, 1'b0, '0, 1'b0);
    idle(1'b1);
    for (int j = 0; j < N; j++) begin
      chk("rr_valid", 64'(out_valid), 64'h1);
      chk("rr_src",   64'(out_src),   64'(j));
      chk("rr_addr",  64'(out_addr),  64'(32'h100 + j));
      idle(1'b1);
    end

    for (int c = 0; c < 300; c++) begin
      sa = {$urandom, $urandom, $urandom, $urandom};
      cycle(4'($urandom_range(0, 15)), sa, $urandom_range(0, 3) != 0, 1'b0, '0, 1'b0);
    end
    for (int i = 0; i < 6; i++) idle(1'b1);

    // protocol errors: multi-hot, idle-source and blocked-slot grants
    sa = '0;
    sa[1*AW +: AW] = 32'h55;
    cycle(4'b0010, sa, 1'b1, 1'b0, '0, 1'b0);
    cycle('0, '0, 1'b0, 1'b1, 4'b0011, 1'b1);
    chk("err_multi",      64'(err_grant),   64'h1);
    chk("err_no_pop",     64'(arb_request), 64'h2);
    chk("err_out_valid",  64'(out_valid),   64'h0);
    cycle('0, '0, 1'b0, 1'b1, 4'b1000, 1'b1);
    chk("err_idle_pop",   64'(arb_request), 64'h2);
    idle(1'b0);
    chk("err_then_ok",    64'(out_addr),    64'h55);
    cycle('0, '0, 1'b0, 1'b1, 4'b0001, 1'b1);
    chk("err_blk_valid",  64'(out_valid),   64'h1);
    chk("err_blk_addr",   64'(out_addr),    64'h55);
    chk("err_sticky",     64'(err_grant),   64'h1);
    idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
